// File: rtl/acc_out_pkg.sv
// Shared definitions for the accelerator output stage: command codes, FSM
// states and the width-generic saturating adder used by every lane.
package acc_out_pkg;

    localparam logic [2:0] CMD_ACC  = 3'b001;
    localparam logic [2:0] CMD_PASS = 3'b010;
    localparam logic [2:0] CMD_PACK = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_PACK = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               ovf;
    } sat_res_t;

    // Adds two sign-extended operands and fits the result into a w-bit signed
    // range (w <= 64); sat selects clamping, otherwise the result wraps.
    function automatic sat_res_t satAdd(input logic signed [63:0] a,
                                        input logic signed [63:0] b,
                                        input int                 w,
                                        input logic               sat);
        logic signed [64:0] full;
        logic signed [64:0] maxV;
        logic signed [64:0] minV;
        logic signed [64:0] wrapped;
        sat_res_t           res;
        full    = {a[63], a} + {b[63], b};
        maxV    = (65'sd1 <<< (w - 1)) - 65'sd1;
        minV    = -maxV - 65'sd1;
        wrapped = (full <<< (65 - w)) >>> (65 - w);
        res.ovf = (full > maxV) || (full < minV);
        if (sat && (full > maxV)) begin
            res.sum = maxV[63:0];
        end else if (sat && (full < minV)) begin
            res.sum = minV[63:0];
        end else begin
            res.sum = wrapped[63:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One lane of the output stage: accumulator plus sticky overflow flag.
// o_sum/o_ovf show the result including the current input beat.
module acc_lane
    import acc_out_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_accEn,
    input  logic                     i_last,
    input  logic                     i_flush,
    input  logic signed [DATA_W-1:0] i_data,
    output logic        [ACC_W-1:0]  o_sum,
    output logic                     o_ovf
);

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;
    sat_res_t                w_add;

    always_comb begin
        w_add = satAdd(64'(r_acc), 64'(i_data), ACC_W, (SAT != 0));
    end

    assign o_sum = w_add.sum[ACC_W-1:0];
    assign o_ovf = r_ovf | w_add.ovf;

    // The last beat of a sequence hands its result to the output register,
    // so the lane restarts from zero for the next sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_flush) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_accEn) begin
            if (i_last) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_add.sum[ACC_W-1:0];
                r_ovf <= o_ovf;
            end
        end
    end

endmodule

// File: rtl/acc_out_array.sv
// Multi-lane output stage: accumulates, passes through or packs input beats
// and holds one result word on a valid/ready port toward write-back.
module acc_out_array
    import acc_out_pkg::*;
#(
    parameter int CH     = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int SAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH*DATA_W-1:0]   in_data,
    input  logic [2:0]             in_cmd,
    input  logic                   in_last,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH*ACC_W-1:0]    out_data,
    output logic [CH-1:0]          out_ovf,
    output logic                   seq_err
);

    localparam int PACK_BEATS = ACC_W / DATA_W;
    localparam int BEAT_W     = CH * DATA_W;
    localparam int CNT_W      = (PACK_BEATS > 1) ? $clog2(PACK_BEATS) : 1;

    state_t               r_state;
    state_t               w_stateNext;
    logic [CNT_W-1:0]     r_packCnt;
    logic [CNT_W-1:0]     w_packIdx;
    logic [CH*ACC_W-1:0]  r_packBuf;
    logic [CH*ACC_W-1:0]  w_packWord;
    logic [CH*ACC_W-1:0]  r_outData;
    logic [CH*ACC_W-1:0]  w_outNext;
    logic [CH*ACC_W-1:0]  w_accWord;
    logic [CH*ACC_W-1:0]  w_passWord;
    logic [CH-1:0]        r_outOvf;
    logic [CH-1:0]        w_ovfNext;
    logic [CH-1:0]        w_laneOvf;
    logic                 r_outValid;
    logic                 r_seqErr;
    logic                 w_accept;
    logic                 w_isAcc;
    logic                 w_isPass;
    logic                 w_isPack;
    logic                 w_packDone;
    logic                 w_emit;
    logic                 w_modeErr;
    logic                 w_flushAcc;

    assign in_ready  = !clear && (!r_outValid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_isAcc   = (in_cmd == CMD_ACC);
    assign w_isPass  = (in_cmd == CMD_PASS);
    assign w_isPack  = (in_cmd == CMD_PACK);

    // A real command that belongs to another sequence type abandons the
    // partial sequence; NOPs never do.
    assign w_modeErr  = w_accept &&
                        (((r_state == ST_ACC)  && (w_isPass || w_isPack)) ||
                         ((r_state == ST_PACK) && (w_isAcc  || w_isPass)));
    assign w_flushAcc = clear || (w_accept && (r_state == ST_ACC) && (w_isPass || w_isPack));

    assign w_packIdx  = (r_state == ST_PACK) ? r_packCnt : '0;
    assign w_packDone = (w_packIdx == CNT_W'(PACK_BEATS - 1)) || in_last;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        acc_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SAT    (SAT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_accEn (w_accept && w_isAcc),
            .i_last  (in_last),
            .i_flush (w_flushAcc),
            .i_data  (in_data[c*DATA_W +: DATA_W]),
            .o_sum   (w_accWord[c*ACC_W +: ACC_W]),
            .o_ovf   (w_laneOvf[c])
        );
        assign w_passWord[c*ACC_W +: ACC_W] = ACC_W'($signed(in_data[c*DATA_W +: DATA_W]));
    end

    always_comb begin
        w_packWord = (r_state == ST_PACK) ? r_packBuf : '0;
        w_packWord[w_packIdx*BEAT_W +: BEAT_W] = in_data;
    end

    always_comb begin
        w_stateNext = r_state;
        w_emit      = 1'b0;
        w_outNext   = w_accWord;
        w_ovfNext   = '0;
        if (clear) begin
            w_stateNext = ST_IDLE;
        end else if (w_accept) begin
            case (in_cmd)
                CMD_ACC: begin
                    if (in_last) begin
                        w_stateNext = ST_IDLE;
                        w_emit      = 1'b1;
                        w_ovfNext   = w_laneOvf;
                    end else begin
                        w_stateNext = ST_ACC;
                    end
                end
                CMD_PASS: begin
                    w_stateNext = ST_IDLE;
                    w_emit      = 1'b1;
                    w_outNext   = w_passWord;
                end
                CMD_PACK: begin
                    if (w_packDone) begin
                        w_stateNext = ST_IDLE;
                        w_emit      = 1'b1;
                        w_outNext   = w_packWord;
                    end else begin
                        w_stateNext = ST_PACK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_packCnt <= '0;
            r_packBuf <= '0;
        end else if (clear || (w_accept && (w_isAcc || w_isPass))) begin
            r_packCnt <= '0;
            r_packBuf <= '0;
        end else if (w_accept && w_isPack) begin
            if (w_packDone) begin
                r_packCnt <= '0;
                r_packBuf <= '0;
            end else begin
                r_packCnt <= w_packIdx + CNT_W'(1);
                r_packBuf <= w_packWord;
            end
        end
    end

    // Single output register: a new emitting beat can only be accepted when
    // the held word is free or leaving on this same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outOvf   <= '0;
            r_seqErr   <= 1'b0;
        end else begin
            r_seqErr <= w_modeErr;
            if (w_emit) begin
                r_outValid <= 1'b1;
                r_outData  <= w_outNext;
                r_outOvf   <= w_ovfNext;
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_ovf   = r_outOvf;
    assign seq_err   = r_seqErr;

endmodule

// File: tb/tb_acc_out_array.sv
// Directed bench for acc_out_array: default instance plus two 20-bit
// accumulator instances (saturating and wrapping) driven in lockstep.
module tb_acc_out_array;
    import acc_out_pkg::*;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic [63:0]  inData;
    logic [2:0]   inCmd;
    logic         inLast;
    logic         clearIn;
    logic         outReady;

    logic         inReady;
    logic         outValid;
    logic [127:0] outData;
    logic [3:0]   outOvf;
    logic         seqErr;

    logic         satInReady;
    logic         satOutValid;
    logic [79:0]  satOutData;
    logic [3:0]   satOutOvf;
    logic         satSeqErr;

    logic         wrapInReady;
    logic         wrapOutValid;
    logic [79:0]  wrapOutData;
    logic [3:0]   wrapOutOvf;
    logic         wrapSeqErr;

    int total;
    int bad;

    localparam logic [63:0] PACK_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PACK_B = 64'hFEDC_BA98_7654_3210;

    acc_out_array #(.CH(4), .DATA_W(16), .ACC_W(32), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_data(inData), .in_cmd(inCmd), .in_last(inLast), .clear(clearIn),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .out_ovf(outOvf), .seq_err(seqErr)
    );

    acc_out_array #(.CH(4), .DATA_W(16), .ACC_W(20), .SAT(1)) dutSat (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(satInReady),
        .in_data(inData), .in_cmd(inCmd), .in_last(inLast), .clear(clearIn),
        .out_valid(satOutValid), .out_ready(outReady), .out_data(satOutData),
        .out_ovf(satOutOvf), .seq_err(satSeqErr)
    );

    acc_out_array #(.CH(4), .DATA_W(16), .ACC_W(20), .SAT(0)) dutWrap (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(wrapInReady),
        .in_data(inData), .in_cmd(inCmd), .in_last(inLast), .clear(clearIn),
        .out_valid(wrapOutValid), .out_ready(outReady), .out_data(wrapOutData),
        .out_ovf(wrapOutOvf), .seq_err(wrapSeqErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] lanes(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then leaves the bench 1 time unit past the
    // edge so outputs are sampled well away from the clock.
    task automatic applyStimulus(input logic valid, input logic [2:0] cmd,
                                 input logic [63:0] data, input logic last,
                                 input logic clr);
        inValid = valid;
        inCmd   = cmd;
        inData  = data;
        inLast  = last;
        clearIn = clr;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
        clearIn = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inCmd    = 3'b000;
        inLast   = 1'b0;
        clearIn  = 1'b0;
        outReady = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 128'(outValid), 128'(1'b0));
        checkOutput("rst_data",  outData, 128'h0);
        checkOutput("rst_ovf",   128'(outOvf), 128'h0);
        checkOutput("rst_seqerr", 128'(seqErr), 128'(1'b0));
        rst = 1'b1;
        #1;
        checkOutput("rst_inready", 128'(inReady), 128'(1'b1));

        // Saturation and wrap on lane1 with a 20-bit accumulator
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b1, CMD_ACC, lanes(16'h0, 16'h7FFF, 16'h0, 16'h0), (i == 17), 1'b0);
        end
        checkOutput("sat_valid", 128'(satOutValid), 128'(1'b1));
        checkOutput("sat_data",  128'(satOutData), 128'({20'h0, 20'h0, 20'h7FFFF, 20'h0}));
        checkOutput("sat_ovf",   128'(satOutOvf), 128'(4'b0010));
        checkOutput("wrap_data", 128'(wrapOutData), 128'({20'h0, 20'h0, 20'h87FEF, 20'h0}));
        checkOutput("wrap_ovf",  128'(wrapOutOvf), 128'(4'b0010));
        checkOutput("wide_data", outData, {32'h0, 32'h0, 32'h0008_7FEF, 32'h0});
        checkOutput("wide_ovf",  128'(outOvf), 128'h0);
        applyStimulus(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
        checkOutput("drain1_valid", 128'(outValid), 128'(1'b0));

        // Plain accumulation 5 + (-2) + 7
        applyStimulus(1'b1, CMD_ACC, lanes(16'd5, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
        applyStimulus(1'b1, CMD_ACC, lanes(16'hFFFE, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
        checkOutput("acc_midvalid", 128'(outValid), 128'(1'b0));
        applyStimulus(1'b1, CMD_ACC, lanes(16'd7, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0);
        checkOutput("acc_valid", 128'(outValid), 128'(1'b1));
        checkOutput("acc_data",  outData, 128'd10);
        checkOutput("acc_ovf",   128'(outOvf), 128'h0);
        applyStimulus(1'b1, CMD_ACC, lanes(16'd4, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0);
        checkOutput("acc_restart", outData, 128'd4);
        applyStimulus(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);

        // Packing two beats, then a single short beat
        applyStimulus(1'b1, CMD_PACK, PACK_A, 1'b0, 1'b0);
        checkOutput("pack_midvalid", 128'(outValid), 128'(1'b0));
        applyStimulus(1'b1, CMD_PACK, PACK_B, 1'b0, 1'b0);
        checkOutput("pack_valid", 128'(outValid), 128'(1'b1));
        checkOutput("pack_full",  outData, {PACK_B, PACK_A});
        applyStimulus(1'b1, CMD_PACK, PACK_A, 1'b1, 1'b0);
        checkOutput("pack_short", outData, {64'h0, PACK_A});

        // Backpressure holds the pending word and blocks input
        outReady = 1'b0;
        inValid  = 1'b1;
        inCmd    = CMD_PASS;
        inData   = lanes(16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_inready", 128'(inReady), 128'(1'b0));
            checkOutput("bp_hold",    outData, {64'h0, PACK_A});
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp_release_ready", 128'(inReady), 128'(1'b1));
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("bp_pass_valid", 128'(outValid), 128'(1'b1));
        checkOutput("bp_pass_data",  outData,
                    {32'hFFFF_FFFF, 32'h0000_7FFF, 32'h0000_0001, 32'hFFFF_8000});
        checkOutput("bp_pass_ovf", 128'(outOvf), 128'h0);
        applyStimulus(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
        checkOutput("drain2_valid", 128'(outValid), 128'(1'b0));

        // Clear during accumulation drops both the partial sum and the beat
        applyStimulus(1'b1, CMD_ACC, lanes(16'd4, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
        applyStimulus(1'b1, CMD_ACC, lanes(16'd5, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
        inValid = 1'b1;
        inCmd   = CMD_ACC;
        inData  = lanes(16'd100, 16'h0, 16'h0, 16'h0);
        inLast  = 1'b1;
        clearIn = 1'b1;
        #1;
        checkOutput("clr_inready", 128'(inReady), 128'(1'b0));
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
        clearIn = 1'b0;
        checkOutput("clr_novalid", 128'(outValid), 128'(1'b0));
        applyStimulus(1'b1, CMD_ACC, lanes(16'd3, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0);
        checkOutput("clr_after", outData, 128'd3);
        applyStimulus(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);

        // Mode change mid-ACC
        applyStimulus(1'b1, CMD_ACC, lanes(16'd6, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
        checkOutput("err_quiet", 128'(seqErr), 128'(1'b0));
        applyStimulus(1'b1, CMD_PASS, lanes(16'd2, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
        checkOutput("err_pulse", 128'(seqErr), 128'(1'b1));
        checkOutput("err_pass_valid", 128'(outValid), 128'(1'b1));
        checkOutput("err_pass_data", outData, 128'd2);
        applyStimulus(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
        checkOutput("err_pulse_end", 128'(seqErr), 128'(1'b0));
        applyStimulus(1'b1, CMD_ACC, lanes(16'd1, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0);
        checkOutput("err_discarded", outData, 128'd1);

        // Reset in the middle of a pack sequence
        applyStimulus(1'b1, CMD_PACK, PACK_A, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_valid", 128'(outValid), 128'(1'b0));
        checkOutput("midrst_data",  outData, 128'h0);
        checkOutput("midrst_ovf",   128'(outOvf), 128'h0);
        checkOutput("midrst_seqerr", 128'(seqErr), 128'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, CMD_PACK, PACK_B, 1'b0, 1'b0);
        checkOutput("postrst_midvalid", 128'(outValid), 128'(1'b0));
        applyStimulus(1'b1, CMD_PACK, PACK_A, 1'b0, 1'b0);
        checkOutput("postrst_valid", 128'(outValid), 128'(1'b1));
        checkOutput("postrst_pack",  outData, {PACK_A, PACK_B});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_out_array.md
# acc_out_array

Multi-channel output stage for the accelerator datapath. It takes per-lane results from the compute array and, per beat, either accumulates them, passes them through, or packs successive beats into one wide output word. It then presents the result on a valid/ready output port to the write-back path. It supersedes the single-lane, unhandshaked output accumulator, adding lanes, saturation, packing and backpressure.

## Interface
- `CH`, 4, number of lanes.
- `DATA_W`, 16, signed input width per lane.
- `ACC_W`, 32, signed accumulator/output width per lane. Must be an integer multiple of `DATA_W`, and `ACC_W` ≥ `DATA_W`.
- `SAT`, 1, 1 = saturating accumulate, 0 = wrap-around.
- Derived: `PACK_BEATS = ACC_W/DATA_W`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready` at the rising edge.
- `in_data`  in  `CH*DATA_W`  lane c at `[c*DATA_W +: DATA_W]`.
- `in_cmd`  in  3  per-beat command: 001 ACC, 010 PASS, 011 PACK; others are NOP.
- `in_last`  in  1  last beat of an ACC or PACK sequence.
- `clear`  in  1  synchronous flush of accumulation/pack state.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  `CH*ACC_W`  result word.
- `out_ovf`  out  `CH`  per-lane saturation/overflow occurred in this result (ACC only, else 0).
- `seq_err`  out  1  one-cycle pulse: command changed mid-sequence.

## Operation
- **FSM states:**
  - IDLE: no partial sequence.
  - ACC: accumulation in progress.
  - PACK: packing in progress.
- **ACC beat:** `acc[c] += sext(in_data[c])`.
  - SAT=1: clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1] and set the sticky `ovf[c]`.
  - SAT=0: wrap; `ovf[c]` set on signed overflow.
  - IDLE→ACC on the first beat.
  - `in_last`: load the output register with the result including this beat, then zero `acc`/`ovf` → IDLE.
- **PASS beat:**
  - Output register ← lane-wise `sext(in_data[c])`; `out_ovf`=0.
  - State unchanged, but only legal in IDLE; see mode change below.
- **PACK beat k:**
  - Beat k (k=0..PACK_BEATS−1) written to `out_data[k*CH*DATA_W +: CH*DATA_W]`.
  - Emits when k = PACK_BEATS−1 or `in_last`. Unfilled slices read 0.
  - Then the count resets → IDLE.
- **NOP:** beat consumed, no effect.
- **Mode change mid-sequence:** a beat with ACC/PASS/PACK while in a different non-IDLE state.
  - Partial state is discarded and `seq_err` pulses.
  - The beat is then processed as the first beat of its own command.
- **`clear`:**
  - Zeroes `acc`, `ovf` and the pack count → IDLE.
  - Forces `in_ready`=0 that cycle, so a simultaneous beat is not accepted.
  - A pending output word is kept.
- **Backpressure:** `in_ready = !clear & (!out_valid | out_ready)`.
  - Single output register; no skid buffer.
  - `out_data`/`out_ovf` hold stable while `out_valid & !out_ready`.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_ovf`=0, `seq_err`=0.
  - `acc`=0, state IDLE, pack count 0.
  - `in_ready` is 1 from the first cycle after reset deassertion (combinational).
- **Latency:** an emitting beat accepted at edge t gives `out_valid`=1 after edge t.
- **Output handshake:** the output transfers at the edge with `out_valid & out_ready`.
  - The same edge may accept a new emitting beat, which reloads the register, so `out_valid` stays 1.
  - Otherwise `out_valid` drops to 0.
- **Full throughput:** one beat per cycle while `out_ready`=1.
- **`seq_err`:** pulses in the cycle after the offending beat.
- **Reset mid-sequence:** all state is lost immediately; there is no output for the partial sequence.

## Structure
- **Package `acc_out_pkg`:**
  - Command encodings `CMD_ACC`/`CMD_PASS`/`CMD_PACK`.
  - FSM state enum.
  - Saturating-add function parameterised by width.
- **Sub-module `acc_lane`:**
  - Holds one lane's `acc` and `ovf` registers plus the saturating adder.
  - Instantiated `CH` times via generate.
  - The top level holds the FSM, pack register/count and output register.

## Test plan
Default parameters unless noted.
1. **ACC:** lane0 beats 5, −2, 7 (`in_last` on the 3rd) → one cycle later `out_valid`=1, lane0 = 10, `out_ovf`=0; accumulator reads 0 for the next sequence.
2. **Saturation** (`ACC_W`=20, `SAT`=1): lane1 gets 0x7FFF for 17 beats, last on the 17th → lane1 = 524287, `out_ovf[1]`=1. With `SAT`=0 → wrapped value 557039−2^20 = −491537, `out_ovf[1]`=1.
3. **PACK:** beats A=64'h0123_4567_89AB_CDEF, B=64'hFEDC_BA98_7654_3210 → `out_data` = {B,A}. Single beat A with `in_last` → {64'h0, A}.
4. **Backpressure:** `out_ready`=0 for 5 cycles with the output pending → `in_ready`=0 and `out_data` stable throughout. Release → the word transfers and the next beat is accepted that same edge.
5. **`clear` during ACC:** after 2 beats (sum 9), `clear` together with `in_valid` → beat not accepted. Next sequence 3, last → 3.
6. **Errors and reset:**
   - PASS beat during ACC → `seq_err` pulse and the PASS output emitted.
   - `rst` low mid-PACK → all outputs 0.
   - After release, a full PACK sequence produces a correct word.
